// File: rtl/lcd_bus_arbiter_if.sv
// lcd_bus_arbiter_if
//   Bundles the two requester handshakes and the HD44780 bus pins that the
//   arbiter owns.
//   master modport: requester side (drives req/rs/data, observes ack/busy/LCD pins)
//   slave  modport: arbiter side (samples requests, drives ack/busy/LCD pins)
//   Signals:
//     req0/rs0/data0/ack0  port 0 (init/command writes)
//     req1/rs1/data1/ack1  port 1 (character writes)
//     busy                 arbiter is running a timed write cycle
//     LCD_RS/LCD_RW/LCD_EN/LCD_DATA  HD44780 bus
interface lcd_bus_arbiter_if;
  logic       req0;
  logic       rs0;
  logic [7:0] data0;
  logic       ack0;
  logic       req1;
  logic       rs1;
  logic [7:0] data1;
  logic       ack1;
  logic       busy;
  logic       LCD_RS;
  logic       LCD_RW;
  logic       LCD_EN;
  logic [7:0] LCD_DATA;

  modport master (
    output req0, rs0, data0, req1, rs1, data1,
    input  ack0, ack1, busy, LCD_RS, LCD_RW, LCD_EN, LCD_DATA
  );

  modport slave (
    input  req0, rs0, data0, req1, rs1, data1,
    output ack0, ack1, busy, LCD_RS, LCD_RW, LCD_EN, LCD_DATA
  );
endinterface

// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter
//   Sole owner of the HD44780 character-LCD bus. Two requesters share it
//   (port 0: init/command writes, port 1: character writes). Every grant runs
//   a timed write cycle: setup, EN pulse, hold, then an execution wait that is
//   longer for clear/home commands.
//   Ports:
//     Clock  system clock, all state on the rising edge
//     Reset  asynchronous reset, active-high
//     bus    lcd_bus_arbiter_if.slave (request handshakes, busy, LCD pins)
//   Configuration:
//     LCD_RR_ARB_EN  defined: round-robin arbitration between the two ports;
//                    undefined: fixed priority, port 0 over port 1.
module lcd_bus_arbiter #(
  parameter int SETUP_CYC    = 2,
  parameter int EN_CYC       = 12,
  parameter int HOLD_CYC     = 2,
  parameter int WAIT_CYC     = 2000,
  parameter int CLR_WAIT_CYC = 82000
) (
  input logic              Clock,
  input logic              Reset,
  lcd_bus_arbiter_if.slave bus
);

  localparam int MAX_A   = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
  localparam int MAX_B   = (HOLD_CYC > WAIT_CYC) ? HOLD_CYC : WAIT_CYC;
  localparam int MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_ALL = (MAX_AB > CLR_WAIT_CYC) ? MAX_AB : CLR_WAIT_CYC;
  localparam int CNT_W   = $clog2(MAX_ALL + 1);

  // Reload values: the counter runs N-1 down to 0, giving N cycles per state.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_LD  = CNT_W'(WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LD   = CNT_W'(CLR_WAIT_CYC - 1);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, WAIT} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             lcd_rs_q, lcd_rs_next;
  logic [7:0]       lcd_data_q, lcd_data_next;
  logic             ack0_q, ack0_next;
  logic             ack1_q, ack1_next;
  logic             win1;
  logic             clr_cmd;

`ifdef LCD_RR_ARB_EN
  // Last-grant pointer; starts at 1 so port 0 wins the first contested grant.
  logic last_grant;

  always_comb begin
    win1 = bus.req1;
    if (bus.req0 && bus.req1) win1 = ~last_grant;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) last_grant <= 1'b1;
    else if (state == IDLE && (bus.req0 || bus.req1)) last_grant <= win1;
  end
`else
  always_comb win1 = bus.req1 && !bus.req0;
`endif

  // Clear display / return home take far longer to execute on the HD44780.
  assign clr_cmd = !lcd_rs_q && (lcd_data_q[7:2] == 6'b0);

  // Next-state, counter reload and grant latching.
  always_comb begin
    state_next    = state;
    cnt_next      = (cnt != '0) ? cnt - 1'b1 : cnt;
    lcd_rs_next   = lcd_rs_q;
    lcd_data_next = lcd_data_q;
    ack0_next     = 1'b0;
    ack1_next     = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = cnt;
        if (bus.req0 || bus.req1) begin
          state_next = SETUP;
          cnt_next   = SETUP_LD;
          if (win1) begin
            lcd_rs_next   = bus.rs1;
            lcd_data_next = bus.data1;
            ack1_next     = 1'b1;
          end else begin
            lcd_rs_next   = bus.rs0;
            lcd_data_next = bus.data0;
            ack0_next     = 1'b1;
          end
        end
      end
      SETUP: if (cnt == '0) begin state_next = PULSE; cnt_next = EN_LD; end
      PULSE: if (cnt == '0) begin state_next = HOLD;  cnt_next = HOLD_LD; end
      HOLD:  if (cnt == '0) begin
               state_next = WAIT;
               cnt_next   = clr_cmd ? CLR_LD : WAIT_LD;
             end
      WAIT:  if (cnt == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; reset abandons any transfer in flight.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      cnt        <= '0;
      lcd_rs_q   <= 1'b0;
      lcd_data_q <= 8'h00;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      lcd_rs_q   <= lcd_rs_next;
      lcd_data_q <= lcd_data_next;
      ack0_q     <= ack0_next;
      ack1_q     <= ack1_next;
    end
  end

  // EN is decoded from the state register so an async reset drops it at once.
  assign bus.LCD_EN   = (state == PULSE);
  assign bus.busy     = (state != IDLE);
  assign bus.LCD_RW   = 1'b0;
  assign bus.LCD_RS   = lcd_rs_q;
  assign bus.LCD_DATA = lcd_data_q;
  assign bus.ack0     = ack0_q;
  assign bus.ack1     = ack1_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// tb_lcd_bus_arbiter
//   Scoreboard bench for lcd_bus_arbiter. A time-slot model of the arbiter
//   predicts each grant (port, latched RS/DATA, grant edge, busy length) and
//   queues it; a monitor pops an entry on every ack and checks the ensuing
//   write cycle on the LCD pins. Short wait parameters keep run time small.
module tb_lcd_bus_arbiter;
  localparam int S = 2;
  localparam int E = 12;
  localparam int H = 2;
  localparam int W = 20;
  localparam int C = 50;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  always #5 Clock = ~Clock;

  lcd_bus_arbiter_if bus();

  lcd_bus_arbiter #(
    .SETUP_CYC(S), .EN_CYC(E), .HOLD_CYC(H), .WAIT_CYC(W), .CLR_WAIT_CYC(C)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus(bus)
  );

  typedef struct {
    int         port;
    logic       rs;
    logic [7:0] data;
    int         grant_edge;
    int         busy_len;
  } xfer_t;

  xfer_t exp_q[$];
  int    errors     = 0;
  int    checks     = 0;
  int    edge_cnt   = 0;
  int    next_free  = 0;
  int    model_last = 1;
  xfer_t m_x;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edge_cnt);
    end
  endtask

  function automatic int xfer_len(input logic rs, input logic [7:0] data);
    return S + E + H + ((rs == 1'b0 && data < 8'd4) ? C : W);
  endfunction

  // Reference model: the bus is free again one idle cycle after a transfer's
  // busy window; any request present at a free edge is granted there.
  always @(posedge Clock) begin
    edge_cnt++;
    if (Reset) begin
      exp_q.delete();
      next_free  = edge_cnt + 1;
      model_last = 1;
    end else if (edge_cnt >= next_free && (bus.req0 || bus.req1)) begin
`ifdef LCD_RR_ARB_EN
      if (bus.req0 && bus.req1) m_x.port = (model_last == 1) ? 0 : 1;
      else m_x.port = bus.req0 ? 0 : 1;
`else
      m_x.port = bus.req0 ? 0 : 1;
`endif
      m_x.rs         = (m_x.port == 1) ? bus.rs1 : bus.rs0;
      m_x.data       = (m_x.port == 1) ? bus.data1 : bus.data0;
      m_x.grant_edge = edge_cnt;
      m_x.busy_len   = xfer_len(m_x.rs, m_x.data);
      exp_q.push_back(m_x);
      next_free  = edge_cnt + m_x.busy_len + 1;
      model_last = m_x.port;
    end
  end

  // Monitor: one scoreboard entry per ack, then timing of the write cycle.
  bit    mon_active = 1'b0;
  xfer_t mon_cur;
  int    mon_cyc, mon_en_rise, mon_en_len;

  always @(negedge Clock) begin
    if (Reset) begin
      mon_active = 1'b0;
    end else begin
      if (mon_active) begin
        mon_cyc++;
        if (bus.LCD_EN) begin
          if (mon_en_len == 0) mon_en_rise = mon_cyc;
          mon_en_len++;
        end
        if (!bus.busy || mon_cyc == mon_cur.busy_len) begin
          checkOutput("busy_fall", int'(bus.busy), 0);
          checkOutput("busy_len", mon_cyc, mon_cur.busy_len);
          checkOutput("en_rise", mon_en_rise, S);
          checkOutput("en_len", mon_en_len, E);
          checkOutput("data_hold", int'(bus.LCD_DATA), int'(mon_cur.data));
          checkOutput("rs_hold", int'(bus.LCD_RS), int'(mon_cur.rs));
          mon_active = 1'b0;
        end
      end else begin
        checkOutput("en_idle", int'(bus.LCD_EN), 0);
      end
      if (bus.ack0 || bus.ack1) begin
        checkOutput("ack_onehot", int'(bus.ack0 && bus.ack1), 0);
        checkOutput("ack_after_idle", int'(mon_active), 0);
        checkOutput("ack_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          mon_cur = exp_q.pop_front();
          checkOutput("ack_port", bus.ack1 ? 1 : 0, mon_cur.port);
          checkOutput("ack_edge", edge_cnt, mon_cur.grant_edge);
          checkOutput("lcd_rs", int'(bus.LCD_RS), int'(mon_cur.rs));
          checkOutput("lcd_data", int'(bus.LCD_DATA), int'(mon_cur.data));
          checkOutput("busy_at_ack", int'(bus.busy), 1);
          checkOutput("lcd_rw", int'(bus.LCD_RW), 0);
          mon_active  = 1'b1;
          mon_cyc     = 0;
          mon_en_len  = 0;
          mon_en_rise = -1;
        end
      end
    end
  end

  task automatic service_cycle();
    @(negedge Clock);
    if (bus.ack0) bus.req0 = 1'b0;
    if (bus.ack1) bus.req1 = 1'b0;
  endtask

  task automatic raise(input int port, input logic rs, input logic [7:0] data);
    if (port == 0) begin bus.rs0 = rs; bus.data0 = data; bus.req0 = 1'b1; end
    else begin bus.rs1 = rs; bus.data1 = data; bus.req1 = 1'b1; end
  endtask

  task automatic raise_random(input int port);
    logic       rs;
    logic [7:0] data;
    rs   = 1'($urandom_range(0, 1));
    data = 8'($urandom_range(0, 255));
    if (!rs && $urandom_range(0, 3) == 0) data = 8'($urandom_range(0, 3));
    raise(port, rs, data);
  endtask

  task automatic wait_reqs_served(input int budget, input string name);
    int n = 0;
    while ((bus.req0 || bus.req1) && n < budget) begin
      service_cycle();
      n++;
    end
    checkOutput({name, "_served"}, int'(bus.req0 || bus.req1), 0);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (bus.busy && n < budget) begin
      service_cycle();
      n++;
    end
    checkOutput({name, "_idle"}, int'(bus.busy), 0);
  endtask

  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      service_cycle();
      if (!bus.req0 && $urandom_range(0, 7) == 0) raise_random(0);
      if (!bus.req1 && $urandom_range(0, 7) == 0) raise_random(1);
    end
  endtask

  initial begin
    #(60000 * 10);
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int acks;
    int order[4];
    int exp_order[4];

    bus.req0 = 1'b0; bus.rs0 = 1'b0; bus.data0 = 8'h00;
    bus.req1 = 1'b0; bus.rs1 = 1'b0; bus.data1 = 8'h00;

    repeat (3) @(negedge Clock);
    checkOutput("rst_en", int'(bus.LCD_EN), 0);
    checkOutput("rst_rs", int'(bus.LCD_RS), 0);
    checkOutput("rst_rw", int'(bus.LCD_RW), 0);
    checkOutput("rst_data", int'(bus.LCD_DATA), 0);
    checkOutput("rst_ack0", int'(bus.ack0), 0);
    checkOutput("rst_ack1", int'(bus.ack1), 0);
    checkOutput("rst_busy", int'(bus.busy), 0);
    Reset = 1'b0;

    $display("[TB] single data write");
    raise(1, 1'b1, 8'h41);
    wait_reqs_served(50, "data_write");
    wait_idle(200, "data_write");

    $display("[TB] clear display");
    service_cycle();
    raise(0, 1'b0, 8'h01);
    wait_reqs_served(50, "clear");
    wait_idle(200, "clear");

    $display("[TB] simultaneous requests");
    service_cycle();
    raise(0, 1'b0, 8'h38);
    raise(1, 1'b0, 8'h30);
    wait_reqs_served(300, "simul");
    wait_idle(200, "simul");

    $display("[TB] request during wait");
    service_cycle();
    raise(0, 1'b0, 8'h80);
    wait_reqs_served(50, "wait_first");
    repeat (S + E + H + 5) service_cycle();
    raise(1, 1'b1, 8'h42);
    wait_reqs_served(100, "wait_second");
    wait_idle(200, "wait_second");

    $display("[TB] reset during pulse");
    service_cycle();
    raise(1, 1'b1, 8'h55);
    wait_reqs_served(50, "rst_xfer");
    n = 0;
    while (!bus.LCD_EN && n < 50) begin @(negedge Clock); n++; end
    checkOutput("pulse_seen", int'(bus.LCD_EN), 1);
    repeat (4) @(negedge Clock);
    #2 Reset = 1'b1;
    #1;
    checkOutput("midrst_en", int'(bus.LCD_EN), 0);
    checkOutput("midrst_busy", int'(bus.busy), 0);
    checkOutput("midrst_data", int'(bus.LCD_DATA), 0);
    checkOutput("midrst_rs", int'(bus.LCD_RS), 0);
    checkOutput("midrst_ack1", int'(bus.ack1), 0);
    repeat (3) @(negedge Clock);
    #2 Reset = 1'b0;
    raise(1, 1'b1, 8'h41);
    wait_reqs_served(50, "post_rst");
    wait_idle(200, "post_rst");

    $display("[TB] both ports re-asserted");
    service_cycle();
    raise(0, 1'b1, 8'h61);
    raise(1, 1'b1, 8'h62);
    acks = 0;
    n = 0;
    while (acks < 4 && n < 1000) begin
      @(negedge Clock);
      n++;
      if (bus.ack0) begin
        order[acks] = 0;
        acks++;
        if (acks < 4) raise(0, 1'b1, 8'($urandom_range(32, 126)));
        else bus.req0 = 1'b0;
      end else if (bus.ack1) begin
        order[acks] = 1;
        acks++;
        if (acks < 4) raise(1, 1'b1, 8'($urandom_range(32, 126)));
        else bus.req1 = 1'b0;
      end
    end
    checkOutput("both_acks", acks, 4);
`ifdef LCD_RR_ARB_EN
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;
`else
    exp_order[0] = 0; exp_order[1] = 0; exp_order[2] = 0; exp_order[3] = 0;
`endif
    for (int i = 0; i < 4; i++) checkOutput($sformatf("grant_order%0d", i), order[i], exp_order[i]);
    wait_reqs_served(300, "both_drain");
    wait_idle(200, "both_drain");

    $display("[TB] random traffic");
    applyStimulus(2500);
    wait_reqs_served(500, "rand_drain");
    wait_idle(200, "rand_drain");

    repeat (3) @(negedge Clock);
    checkOutput("queue_empty", exp_q.size(), 0);
    checkOutput("monitor_idle", int'(mon_active), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
